// File: rtl/ins_fetch_unit_pkg.sv
// Shared definitions for the music instruction path: word layout, opcodes and the fetch classifier.
package music_pkg;

  localparam int unsigned INS_W    = 16;
  localparam logic [3:0]  OP_END   = 4'h0;
  localparam logic [3:0]  OP_BPM   = 4'h1;
  localparam int unsigned NOTE_BIT = 15;

  localparam logic [INS_W-1:0] END_WORD         = 16'h0000;
  // Substituted for undecodable words so the executor simply stops.
  localparam logic [INS_W-1:0] EXEC_PLACEHOLDER = END_WORD;

  typedef enum logic [1:0] {
    ClsNote,
    ClsBpm,
    ClsEnd,
    ClsInvalid
  } ins_class_e;

  function automatic ins_class_e classify(input logic [INS_W-1:0] word);
    logic [3:0] op;
    op = word[INS_W-1 -: 4];
    if (word[NOTE_BIT])   return ClsNote;
    if (op == OP_END)     return ClsEnd;
    if (op == OP_BPM)     return ClsBpm;
    return ClsInvalid;
  endfunction

endpackage

// File: rtl/ins_fetch_unit_if.sv
// SRAM read port and executor handshake of the instruction fetch unit.
interface ins_fetch_unit_if
  import music_pkg::*;
#(
  parameter int unsigned ADDR_W = 18
);

  logic [ADDR_W-1:0] sram_a;
  logic              sram_oe;
  logic [INS_W-1:0]  sram_d;
  logic [INS_W-1:0]  ins_data;
  logic              ins_valid;
  logic              ins_ready;

  modport master (
    output sram_a,
    output sram_oe,
    input  sram_d,
    output ins_data,
    output ins_valid,
    input  ins_ready
  );

  modport slave (
    input  sram_a,
    input  sram_oe,
    output sram_d,
    input  ins_data,
    input  ins_valid,
    output ins_ready
  );

endinterface

// File: rtl/ins_fetch_unit_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is read combinationally from the storage array.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W:0]   level_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign level    = level_q;
  assign pop_data = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ins_fetch_unit.sv
// Fetches music instruction words from async SRAM at a fixed wait-state rate, classifies them
// and buffers them in a FWFT FIFO for the note executor.
module ins_fetch_unit
  import music_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 18,
  parameter int unsigned       DEPTH       = 4,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  ins_fetch_unit_if.master       bus,
  output logic [ADDR_W-1:0]      pc,
  output logic [$clog2(DEPTH):0] level,
  output logic                   halted,
  output logic                   err
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StHold,
    StStopped
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] sram_a_q;
  logic              sram_oe_q;
  logic              halted_q;
  logic              err_q;

  ins_class_e        cls;
  logic              sample;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              full_after_push;
  logic [INS_W-1:0]  push_data;
  logic [INS_W-1:0]  head;
  logic [LVL_W-1:0]  fifo_level;

  assign cls       = classify(bus.sram_d);
  assign sample    = (state_q == StWait) && (cnt_q == '0);
  assign push_data = (cls == ClsInvalid) ? EXEC_PLACEHOLDER : bus.sram_d;
  assign pop       = !fifo_empty && bus.ins_ready;
  // Occupancy after this edge's push, accounting for a simultaneous pop.
  assign full_after_push = (fifo_level == LVL_W'(DEPTH - 1)) && !pop;

  sync_fifo #(
    .WIDTH (INS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sample),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pc_q      <= START_ADDR;
      sram_a_q  <= '0;
      sram_oe_q <= 1'b1;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) state_q <= StAddr;
        end
        StAddr: begin
          sram_a_q  <= pc_q;
          sram_oe_q <= 1'b0;
          cnt_q     <= CNT_W'(WAIT_CYCLES - 1);
          state_q   <= StWait;
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            sram_oe_q <= 1'b1;
            case (cls)
              ClsNote, ClsBpm: begin
                pc_q    <= pc_q + 1'b1;
                state_q <= full_after_push ? StHold : StAddr;
              end
              ClsEnd: begin
                halted_q <= 1'b1;
                state_q  <= StStopped;
              end
              default: begin
                halted_q <= 1'b1;
                err_q    <= 1'b1;
                state_q  <= StStopped;
              end
            endcase
          end
        end
        StHold: begin
          if (!fifo_full) state_q <= StAddr;
        end
        StStopped: begin
          if (start) begin
            pc_q     <= START_ADDR;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            // Buffered words survive a restart; wait for room if they fill the FIFO.
            state_q  <= fifo_full ? StHold : StAddr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sram_a    = sram_a_q;
  assign bus.sram_oe   = sram_oe_q;
  assign bus.ins_data  = head;
  assign bus.ins_valid = !fifo_empty;
  assign pc            = pc_q;
  assign level         = fifo_level;
  assign halted        = halted_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Self-checking bench for ins_fetch_unit: classification vector table, scoreboard on the
// executor handshake, and hand-written sequences for latency, backpressure, errors, wrap and reset.
module tb_ins_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0;
  logic        start1;
  logic [17:0] pc0, pc1;
  logic [2:0]  level0, level1;
  logic        halted0, halted1;
  logic        err0, err1;
  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          oe_low_cnt = 0;

  always #10 clk = ~clk;

  ins_fetch_unit_if #(.ADDR_W(18)) if0 ();
  ins_fetch_unit_if #(.ADDR_W(18)) if1 ();

  assign if0.sram_d = mem0[if0.sram_a[3:0]];
  assign if1.sram_d = mem1[if1.sram_a[3:0]];

  ins_fetch_unit #(
    .ADDR_W (18), .DEPTH (4), .WAIT_CYCLES (2), .START_ADDR (18'h00000)
  ) dut0 (
    .clk (clk), .rst (rst), .start (start0), .bus (if0.master),
    .pc (pc0), .level (level0), .halted (halted0), .err (err0)
  );

  ins_fetch_unit #(
    .ADDR_W (18), .DEPTH (4), .WAIT_CYCLES (2), .START_ADDR (18'h3FFFF)
  ) dut1 (
    .clk (clk), .rst (rst), .start (start1), .bus (if1.master),
    .pc (pc1), .level (level1), .halted (halted1), .err (err1)
  );

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp0;
    logic [15:0] exp1;
    int          n_out;
    logic        exp_err;
    logic [17:0] exp_pc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Scoreboards: compare the head word on every accepted handshake.
  always @(negedge clk) begin
    if (!rst && if0.ins_valid && if0.ins_ready) begin
      if (exp_q0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop0: got %h, expected no word", if0.ins_data);
      end else begin
        chk("pop0", 32'(if0.ins_data), 32'(exp_q0.pop_front()));
      end
    end
    if (!rst && if1.ins_valid && if1.ins_ready) begin
      if (exp_q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop1: got %h, expected no word", if1.ins_data);
      end else begin
        chk("pop1", 32'(if1.ins_data), 32'(exp_q1.pop_front()));
      end
    end
    if (!if0.sram_oe) oe_low_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end
    tick();
    tick();
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic wait_halted0(input int max);
    for (int i = 0; i < max && !halted0; i++) tick();
    if (!halted0) timeout("wait_halted0");
  endtask

  task automatic wait_level0(input logic [2:0] lvl, input int max);
    for (int i = 0; i < max && level0 != lvl; i++) tick();
    if (level0 != lvl) timeout("wait_level0");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h1060, 16'h1060, 16'h0000, 2, 1'b0, 18'd1};
    vecs[1] = '{16'h8123, 16'h8123, 16'h0000, 2, 1'b0, 18'd1};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 1, 1'b0, 18'd0};
    vecs[3] = '{16'h0ABC, 16'h0ABC, 16'h0000, 1, 1'b0, 18'd0};
    vecs[4] = '{16'h2ABC, 16'h0000, 16'h0000, 1, 1'b1, 18'd0};
    vecs[5] = '{16'hF00F, 16'hF00F, 16'h0000, 2, 1'b0, 18'd1};
    vecs[6] = '{16'h7FFF, 16'h0000, 16'h0000, 1, 1'b1, 18'd0};
    vecs[7] = '{16'h1FFF, 16'h1FFF, 16'h0000, 2, 1'b0, 18'd1};

    if0.ins_ready = 1'b0;
    if1.ins_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_sram_a", 32'(if0.sram_a), 32'h0);
    chk("rst_sram_oe", 32'(if0.sram_oe), 32'h1);
    chk("rst_pc", 32'(pc0), 32'h0);
    chk("rst_valid", 32'(if0.ins_valid), 32'h0);
    chk("rst_level", 32'(level0), 32'h0);
    chk("rst_data", 32'(if0.ins_data), 32'h0);
    chk("rst_halted", 32'(halted0), 32'h0);
    chk("rst_err", 32'(err0), 32'h0);
    chk("rst_pc1", 32'(pc1), 32'h3FFFF);

    // First-fetch latency: BPM 96
    mem0[0] = 16'h1060;
    exp_q0.push_back(16'h1060);
    exp_q0.push_back(16'h0000);
    if0.ins_ready = 1'b1;
    pulse_start0();
    chk("lat_e0_oe", 32'(if0.sram_oe), 32'h1);
    tick();
    chk("lat_e1_a", 32'(if0.sram_a), 32'h0);
    chk("lat_e1_oe", 32'(if0.sram_oe), 32'h0);
    tick();
    chk("lat_e2_oe", 32'(if0.sram_oe), 32'h0);
    chk("lat_e2_valid", 32'(if0.ins_valid), 32'h0);
    tick();
    chk("lat_e3_valid", 32'(if0.ins_valid), 32'h1);
    chk("lat_e3_data", 32'(if0.ins_data), 32'h1060);
    chk("lat_e3_pc", 32'(pc0), 32'h1);
    chk("lat_e3_oe", 32'(if0.sram_oe), 32'h1);
    wait_halted0(30);
    wait_level0(3'd0, 10);
    chk("lat_q_empty", 32'(exp_q0.size()), 32'h0);

    // Classification table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      mem0[0] = vecs[v].word;
      if0.ins_ready = 1'b1;
      exp_q0.push_back(vecs[v].exp0);
      if (vecs[v].n_out == 2) exp_q0.push_back(vecs[v].exp1);
      pulse_start0();
      wait_halted0(30);
      wait_level0(3'd0, 10);
      chk($sformatf("vec%0d_err", v), 32'(err0), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_pc", v), 32'(pc0), 32'(vecs[v].exp_pc));
      chk($sformatf("vec%0d_q", v), 32'(exp_q0.size()), 32'h0);
    end

    // Buffer a short program with the executor stalled, then drain
    do_reset();
    mem0[0] = 16'h8123;
    mem0[1] = 16'h8245;
    mem0[2] = 16'h0000;
    if0.ins_ready = 1'b0;
    exp_q0.push_back(16'h8123);
    exp_q0.push_back(16'h8245);
    exp_q0.push_back(16'h0000);
    pulse_start0();
    wait_halted0(40);
    tick();
    oe_low_cnt = 0;
    chk("buf_level", 32'(level0), 32'h3);
    chk("buf_pc", 32'(pc0), 32'h2);
    chk("buf_head", 32'(if0.ins_data), 32'h8123);
    for (int i = 0; i < 10; i++) tick();
    chk("buf_no_sram", 32'(oe_low_cnt), 32'h0);
    if0.ins_ready = 1'b1;
    wait_level0(3'd0, 10);
    tick();
    chk("buf_valid_end", 32'(if0.ins_valid), 32'h0);
    chk("buf_q", 32'(exp_q0.size()), 32'h0);

    // FIFO full: fetch holds until a pop frees a slot
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mem0[i] = 16'h8001 + 16'(i);
      exp_q0.push_back(16'h8001 + 16'(i));
    end
    exp_q0.push_back(16'h0000);
    if0.ins_ready = 1'b0;
    pulse_start0();
    wait_level0(3'd4, 40);
    oe_low_cnt = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("full_level", 32'(level0), 32'h4);
    chk("full_hold", 32'(oe_low_cnt), 32'h0);
    chk("full_pc", 32'(pc0), 32'h4);
    if0.ins_ready = 1'b1;
    tick();
    if0.ins_ready = 1'b0;
    chk("full_after_pop", 32'(level0), 32'h3);
    for (int i = 0; i < 4 && if0.sram_oe; i++) tick();
    if (if0.sram_oe) timeout("full_resume");
    chk("full_resume_a", 32'(if0.sram_a), 32'h4);
    if0.ins_ready = 1'b1;
    wait_halted0(60);
    wait_level0(3'd0, 10);
    chk("full_q", 32'(exp_q0.size()), 32'h0);

    // Invalid opcode, then restart
    do_reset();
    mem0[0] = 16'h8111;
    mem0[1] = 16'h2ABC;
    if0.ins_ready = 1'b1;
    exp_q0.push_back(16'h8111);
    exp_q0.push_back(16'h0000);
    pulse_start0();
    wait_halted0(30);
    wait_level0(3'd0, 10);
    chk("inv_err", 32'(err0), 32'h1);
    chk("inv_halted", 32'(halted0), 32'h1);
    chk("inv_pc", 32'(pc0), 32'h1);
    mem0[0] = 16'h0000;
    exp_q0.push_back(16'h0000);
    pulse_start0();
    chk("restart_err", 32'(err0), 32'h0);
    chk("restart_halted", 32'(halted0), 32'h0);
    chk("restart_pc", 32'(pc0), 32'h0);
    tick();
    chk("restart_a", 32'(if0.sram_a), 32'h0);
    chk("restart_oe", 32'(if0.sram_oe), 32'h0);
    wait_halted0(30);
    wait_level0(3'd0, 10);
    chk("restart_q", 32'(exp_q0.size()), 32'h0);

    // Reset during WAIT with two words buffered
    do_reset();
    for (int i = 0; i < 6; i++) mem0[i] = 16'h8001 + 16'(i);
    if0.ins_ready = 1'b0;
    pulse_start0();
    wait_level0(3'd2, 30);
    tick();
    chk("mid_oe_pre", 32'(if0.sram_oe), 32'h0);
    rst = 1'b1;
    tick();
    chk("mid_level", 32'(level0), 32'h0);
    chk("mid_valid", 32'(if0.ins_valid), 32'h0);
    chk("mid_oe", 32'(if0.sram_oe), 32'h1);
    chk("mid_a", 32'(if0.sram_a), 32'h0);
    chk("mid_pc", 32'(pc0), 32'h0);
    rst = 1'b0;
    exp_q0.delete();
    mem0[0] = 16'h0000;
    exp_q0.push_back(16'h0000);
    if0.ins_ready = 1'b1;
    pulse_start0();
    wait_halted0(30);
    wait_level0(3'd0, 10);
    chk("mid_restart_pc", 32'(pc0), 32'h0);
    chk("mid_restart_q", 32'(exp_q0.size()), 32'h0);

    // PC wrap from the top of the address space
    do_reset();
    mem1[15] = 16'h8111;
    mem1[0]  = 16'h8222;
    mem1[1]  = 16'h0000;
    exp_q1.push_back(16'h8111);
    exp_q1.push_back(16'h8222);
    exp_q1.push_back(16'h0000);
    if1.ins_ready = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("wrap_a0", 32'(if1.sram_a), 32'h3FFFF);
    chk("wrap_oe0", 32'(if1.sram_oe), 32'h0);
    tick();
    tick();
    chk("wrap_pc", 32'(pc1), 32'h0);
    tick();
    chk("wrap_a1", 32'(if1.sram_a), 32'h0);
    chk("wrap_oe1", 32'(if1.sram_oe), 32'h0);
    tick();
    tick();
    tick();
    chk("wrap_a2", 32'(if1.sram_a), 32'h1);
    for (int i = 0; i < 20 && !halted1; i++) tick();
    if (!halted1) timeout("wait_halted1");
    tick();
    tick();
    chk("wrap_pc_end", 32'(pc1), 32'h1);
    chk("wrap_q", 32'(exp_q1.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
